// File: rtl/axi_bridge_mp.sv
// axi_bridge_mp: merges NUM_PORTS cache read ports onto one AXI3 AR/R pair and
// one write port onto AW/W/B. Reads are arbitrated, counted per port and held off
// on RAW_MASK ports while any write is pending.
// Ports: clk/reset (sync, active-high); rd_* request side with one-hot rd_rdy;
//   ret_* demuxed read beats; wr_* write side; ar*/r*/aw*/w*/b* AXI3 master.
// Optional macro AXI_BRIDGE_RR_ARB_EN: round-robin AR grant; otherwise fixed
//   priority with the highest port index winning.
module axi_bridge_mp #(
   parameter int                   NUM_PORTS  = 2,
   parameter int                   MAX_RD_OUT = 4,
   parameter int                   MAX_WR_OUT = 4,
   parameter int                   WR_ID      = 15,
   parameter logic [NUM_PORTS-1:0] RAW_MASK   = 2'b10
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_PORTS-1:0]    rd_req,
   input  logic [32*NUM_PORTS-1:0] rd_addr,
   input  logic [8*NUM_PORTS-1:0]  rd_len,
   input  logic [3*NUM_PORTS-1:0]  rd_size,
   output logic [NUM_PORTS-1:0]    rd_rdy,
   output logic [NUM_PORTS-1:0]    ret_valid,
   output logic [NUM_PORTS-1:0]    ret_last,
   output logic [31:0]             ret_data,
   input  logic                    wr_req,
   input  logic [31:0]             wr_addr,
   input  logic [7:0]              wr_len,
   input  logic [2:0]              wr_size,
   output logic                    wr_addr_ok,
   input  logic [31:0]             wr_wdata,
   input  logic [3:0]              wr_wstrb,
   input  logic                    wr_wlast,
   input  logic                    wr_wvalid,
   output logic                    wr_wready,
   output logic                    wr_data_ok,
   output logic [3:0]              arid,
   output logic [31:0]             araddr,
   output logic [7:0]              arlen,
   output logic [2:0]              arsize,
   output logic [1:0]              arburst,
   output logic [1:0]              arlock,
   output logic [3:0]              arcache,
   output logic [2:0]              arprot,
   output logic                    arvalid,
   input  logic                    arready,
   input  logic [3:0]              rid,
   input  logic [31:0]             rdata,
   input  logic [1:0]              rresp,
   input  logic                    rlast,
   input  logic                    rvalid,
   output logic                    rready,
   output logic [3:0]              awid,
   output logic [31:0]             awaddr,
   output logic [7:0]              awlen,
   output logic [2:0]              awsize,
   output logic [1:0]              awburst,
   output logic [1:0]              awlock,
   output logic [3:0]              awcache,
   output logic [2:0]              awprot,
   output logic                    awvalid,
   input  logic                    awready,
   output logic [3:0]              wid,
   output logic [31:0]             wdata,
   output logic [3:0]              wstrb,
   output logic                    wlast,
   output logic                    wvalid,
   input  logic                    wready,
   input  logic [3:0]              bid,
   input  logic [1:0]              bresp,
   input  logic                    bvalid,
   output logic                    bready
);

   typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA} wst_t;

   wst_t        r_wst;
   logic [3:0]  r_rd_out [NUM_PORTS];
   logic [3:0]  r_wr_out;
   logic        r_arvalid;
   logic [3:0]  r_ar_id;
   logic [31:0] r_ar_addr;
   logic [7:0]  r_ar_len;
   logic [2:0]  r_ar_size;
   logic        r_awvalid;
   logic [31:0] r_aw_addr;
   logic [7:0]  r_aw_len;
   logic [2:0]  r_aw_size;

   logic [NUM_PORTS-1:0] w_elig;
   logic                 w_raw_busy;
   logic                 w_gnt_vld;
   logic [3:0]           w_gnt_idx;
   logic                 w_ar_take;
   logic                 w_wr_acc;
   logic [31:0]          w_sel_addr;
   logic [7:0]           w_sel_len;
   logic [2:0]           w_sel_size;
   logic                 w_unused_ok;

   // Response codes and bid carry nothing this bridge acts on.
   assign w_unused_ok = ^{rresp, bid, bresp};

   assign arburst = 2'b01;
   assign arlock  = 2'b00;
   assign arcache = 4'b0000;
   assign arprot  = 3'b000;
   assign awburst = 2'b01;
   assign awlock  = 2'b00;
   assign awcache = 4'b0000;
   assign awprot  = 3'b000;
   assign rready  = 1'b1;
   assign bready  = 1'b1;
   assign awid    = 4'(WR_ID);
   assign wid     = 4'(WR_ID);

   assign arvalid = r_arvalid;
   assign arid    = r_ar_id;
   assign araddr  = r_ar_addr;
   assign arlen   = r_ar_len;
   assign arsize  = r_ar_size;
   assign awvalid = r_awvalid;
   assign awaddr  = r_aw_addr;
   assign awlen   = r_aw_len;
   assign awsize  = r_aw_size;

   // A write being requested, in the FSM or awaiting B all count as pending, so
   // a same-cycle write request beats a masked read.
   assign w_raw_busy = (r_wr_out != 4'd0) || (r_wst != W_IDLE) || wr_req;

   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         w_elig[p] = rd_req[p] && (r_rd_out[p] < 4'(MAX_RD_OUT))
                     && !(RAW_MASK[p] && w_raw_busy);
      end
   end

`ifdef AXI_BRIDGE_RR_ARB_EN
   logic [3:0] r_ptr;

   // Walk ports starting at r_ptr; the first eligible one wins.
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt_idx = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (!w_gnt_vld && w_elig[p] && (p == ((int'(r_ptr) + i) % NUM_PORTS))) begin
               w_gnt_vld = 1'b1;
               w_gnt_idx = 4'(p);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr <= '0;
      end else if (w_ar_take) begin
         r_ptr <= (w_gnt_idx == 4'(NUM_PORTS - 1)) ? 4'd0 : w_gnt_idx + 4'd1;
      end
   end
`else
   // Later iterations overwrite earlier ones, so the highest index wins.
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt_idx = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (w_elig[p]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = 4'(p);
         end
      end
   end
`endif

   // The AR register can take a new request when empty or draining this cycle.
   assign w_ar_take = w_gnt_vld && (!r_arvalid || arready);

   always_comb begin
      w_sel_addr = '0;
      w_sel_len  = '0;
      w_sel_size = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         rd_rdy[p]    = w_ar_take && (w_gnt_idx == 4'(p));
         ret_valid[p] = rvalid && (rid == 4'(p));
         ret_last[p]  = rvalid && rlast && (rid == 4'(p));
         if (w_gnt_idx == 4'(p)) begin
            w_sel_addr = rd_addr[32*p +: 32];
            w_sel_len  = rd_len[8*p +: 8];
            w_sel_size = rd_size[3*p +: 3];
         end
      end
   end

   assign ret_data = rdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_arvalid <= 1'b0;
         r_ar_id   <= '0;
         r_ar_addr <= '0;
         r_ar_len  <= '0;
         r_ar_size <= '0;
      end else if (w_ar_take) begin
         r_arvalid <= 1'b1;
         r_ar_id   <= w_gnt_idx;
         r_ar_addr <= w_sel_addr;
         r_ar_len  <= w_sel_len;
         r_ar_size <= w_sel_size;
      end else if (arready) begin
         r_arvalid <= 1'b0;
      end
   end

   // Grant and retire in the same cycle cancel out.
   always_ff @(posedge clk) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (reset) begin
            r_rd_out[p] <= '0;
         end else if (rd_rdy[p] && !ret_last[p]) begin
            r_rd_out[p] <= r_rd_out[p] + 4'd1;
         end else if (ret_last[p] && !rd_rdy[p]) begin
            r_rd_out[p] <= r_rd_out[p] - 4'd1;
         end
      end
   end

   assign w_wr_acc   = wr_req && (r_wst == W_IDLE) && (r_wr_out < 4'(MAX_WR_OUT));
   assign wr_addr_ok = w_wr_acc;
   assign wr_data_ok = bvalid;
   assign wvalid     = (r_wst == W_DATA) && wr_wvalid;
   assign wr_wready  = (r_wst == W_DATA) && wready;
   assign wdata      = wr_wdata;
   assign wstrb      = wr_wstrb;
   assign wlast      = wr_wlast;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wst     <= W_IDLE;
         r_awvalid <= 1'b0;
         r_aw_addr <= '0;
         r_aw_len  <= '0;
         r_aw_size <= '0;
         r_wr_out  <= '0;
      end else begin
         if (w_wr_acc && !bvalid) begin
            r_wr_out <= r_wr_out + 4'd1;
         end else if (bvalid && !w_wr_acc) begin
            r_wr_out <= r_wr_out - 4'd1;
         end
         case (r_wst)
            W_IDLE: begin
               if (w_wr_acc) begin
                  r_aw_addr <= wr_addr;
                  r_aw_len  <= wr_len;
                  r_aw_size <= wr_size;
                  r_awvalid <= 1'b1;
                  r_wst     <= W_ADDR;
               end
            end
            W_ADDR: begin
               if (awready) begin
                  r_awvalid <= 1'b0;
                  r_wst     <= W_DATA;
               end
            end
            W_DATA: begin
               if (wr_wvalid && wready && wr_wlast) begin
                  r_wst <= W_IDLE;
               end
            end
            default: r_wst <= W_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_bridge_mp.sv
module tb_axi_bridge_mp;
   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  rd_req;
   logic [63:0] rd_addr;
   logic [15:0] rd_len;
   logic [5:0]  rd_size;
   logic [1:0]  rd_rdy, ret_valid, ret_last;
   logic [31:0] ret_data;
   logic        wr_req;
   logic [31:0] wr_addr;
   logic [7:0]  wr_len;
   logic [2:0]  wr_size;
   logic        wr_addr_ok;
   logic [31:0] wr_wdata;
   logic [3:0]  wr_wstrb;
   logic        wr_wlast, wr_wvalid, wr_wready, wr_data_ok;
   logic [3:0]  arid, arcache;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize, arprot;
   logic [1:0]  arburst, arlock;
   logic        arvalid, arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast, rvalid, rready;
   logic [3:0]  awid, awcache;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize, awprot;
   logic [1:0]  awburst, awlock;
   logic        awvalid, awready;
   logic [3:0]  wid;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast, wvalid, wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid, bready;

   axi_bridge_mp dut (
      .clk(clk), .reset(reset), .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
      .rd_size(rd_size), .rd_rdy(rd_rdy), .ret_valid(ret_valid), .ret_last(ret_last),
      .ret_data(ret_data), .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len),
      .wr_size(wr_size), .wr_addr_ok(wr_addr_ok), .wr_wdata(wr_wdata), .wr_wstrb(wr_wstrb),
      .wr_wlast(wr_wlast), .wr_wvalid(wr_wvalid), .wr_wready(wr_wready),
      .wr_data_ok(wr_data_ok), .arid(arid), .araddr(araddr), .arlen(arlen),
      .arsize(arsize), .arburst(arburst), .arlock(arlock), .arcache(arcache),
      .arprot(arprot), .arvalid(arvalid), .arready(arready), .rid(rid), .rdata(rdata),
      .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready), .awid(awid),
      .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid),
      .awready(awready), .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .wvalid(wvalid), .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid),
      .bready(bready)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int w_seen = 0;
   logic [46:0] ar_q[$];   // {arid, araddr, arlen, arsize}
   logic [40:0] w_q[$];    // {wid, wdata, wstrb, wlast}
   logic [63:0] mon_exp;
   int m_ptr;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
   endtask

   // AXI-side scoreboard: handshakes are sampled on the falling edge.
   always @(negedge clk) begin
      if (!reset && arvalid && arready) begin
         if (ar_q.size() == 0) check("ar_unexpected", 64'd1, 64'd0);
         else begin
            mon_exp = 64'(ar_q.pop_front());
            check("ar_payload", 64'({arid, araddr, arlen, arsize}), mon_exp);
         end
      end
      if (!reset && wvalid && wready) begin
         w_seen++;
         if (w_q.size() == 0) check("w_unexpected", 64'd1, 64'd0);
         else begin
            mon_exp = 64'(w_q.pop_front());
            check("w_beat", 64'({wid, wdata, wstrb, wlast}), mon_exp);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      rd_req = '0; rd_addr = '0; rd_len = '0; rd_size = '0;
      wr_req = 0; wr_addr = '0; wr_len = '0; wr_size = '0;
      wr_wdata = '0; wr_wstrb = '0; wr_wlast = 0; wr_wvalid = 0;
      arready = 1; rid = '0; rdata = '0; rresp = '0; rlast = 0; rvalid = 0;
      awready = 1; wready = 0; bid = '0; bresp = '0; bvalid = 0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      ar_q.delete();
      w_q.delete();
      m_ptr = 0;
   endtask

   task automatic push_ar(input int p, input logic [31:0] a, input logic [7:0] l, input logic [2:0] s);
      ar_q.push_back({4'(p), a, l, s});
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      int eg, k, cyc, w0;
      logic wr_now;

      // Reset state
      do_reset();
      #1;
      check("rst_arvalid", 64'(arvalid), 64'd0);
      check("rst_awvalid", 64'(awvalid), 64'd0);
      check("rst_wvalid", 64'(wvalid), 64'd0);
      check("rst_consts", 64'({rready, bready, arburst, awburst, awid}), 64'({1'b1, 1'b1, 2'b01, 2'b01, 4'hF}));

      // Single read, 4 beats back
      rd_req = 2'b01; rd_addr[31:0] = 32'h1000; rd_len[7:0] = 8'd3; rd_size[2:0] = 3'd2;
      #1;
      check("single_rdy", 64'(rd_rdy), 64'b01);
      push_ar(0, 32'h1000, 8'd3, 3'd2);
      tick();
      rd_req = 2'b00;
      #1;
      check("single_arvalid", 64'(arvalid), 64'd1);
      tick();
      for (int b = 0; b < 4; b++) begin
         rvalid = 1; rid = 4'd0; rdata = 32'hA0 + 32'(b); rlast = (b == 3);
         #1;
         check("ret_valid", 64'(ret_valid), 64'b01);
         check("ret_last", 64'(ret_last), (b == 3) ? 64'b01 : 64'b00);
         check("ret_data", 64'(ret_data), 64'h0A0 + 64'(b));
         tick();
      end
      rid = 4'd5; rlast = 1;
      #1;
      check("ret_bad_id", 64'({ret_valid, ret_last}), 64'd0);
      tick();
      rvalid = 0; rlast = 0;
      #1;
      check("single_rd_out", 64'(dut.r_rd_out[0]), 64'd0);

      // Contention between both ports
      do_reset();
      rd_req = 2'b11;
      rd_addr = {32'h5000, 32'h4000}; rd_len = {8'd2, 8'd1}; rd_size = {3'd2, 3'd2};
      for (int g = 0; g < 4; g++) begin
`ifdef AXI_BRIDGE_RR_ARB_EN
         eg = m_ptr;
         m_ptr = 1 - m_ptr;
`else
         eg = 1;
`endif
         #1;
         check("contend_rdy", 64'(rd_rdy), 64'(1 << eg));
         push_ar(eg, (eg == 1) ? 32'h5000 : 32'h4000, (eg == 1) ? 8'd2 : 8'd1, 3'd2);
         tick();
      end
      rd_req = 2'b00;
      tick(); tick();
      check("contend_drained", 64'(ar_q.size()), 64'd0);

      // RAW hold-off of port 1 while a write is in flight
      do_reset();
      wr_req = 1; wr_addr = 32'h2000; wr_len = 8'd0; wr_size = 3'd2;
      rd_req = 2'b11; rd_addr = {32'h7000, 32'h6000}; rd_len = {8'd1, 8'd0}; rd_size = {3'd1, 3'd2};
      #1;
      check("raw_wr_ok", 64'(wr_addr_ok), 64'd1);
      check("raw_write_wins", 64'(rd_rdy), 64'b01);
      push_ar(0, 32'h6000, 8'd0, 3'd2);
      tick();
      wr_req = 0; rd_req = 2'b10;
      #1;
      check("raw_aw", 64'({awvalid, awid, awaddr, awlen, awsize}), 64'({1'b1, 4'hF, 32'h2000, 8'd0, 3'd2}));
      check("raw_hold_aw", 64'(rd_rdy), 64'd0);
      tick();
      wr_wvalid = 1; wr_wdata = 32'h55; wr_wstrb = 4'hF; wr_wlast = 1; wready = 1;
      w_q.push_back({4'hF, 32'h55, 4'hF, 1'b1});
      #1;
      check("raw_wready", 64'(wr_wready), 64'd1);
      tick();
      wr_wvalid = 0; wr_wlast = 0; wready = 0;
      for (int c = 0; c < 10; c++) begin
         #1;
         check("raw_hold", 64'(rd_rdy), 64'd0);
         tick();
      end
      bvalid = 1; bid = 4'hF;
      #1;
      check("raw_data_ok", 64'(wr_data_ok), 64'd1);
      check("raw_hold_b", 64'(rd_rdy), 64'd0);
      tick();
      bvalid = 0;
      #1;
      check("raw_release", 64'(rd_rdy), 64'b10);
      push_ar(1, 32'h7000, 8'd1, 3'd1);
      tick();
      rd_req = 2'b00;
      tick(); tick();
      check("raw_drained", 64'(ar_q.size()), 64'd0);

      // Outstanding limit and simultaneous grant/retire
      do_reset();
      rd_req = 2'b01; rd_addr[31:0] = 32'h8000; rd_len[7:0] = 8'd0; rd_size[2:0] = 3'd2;
      for (int g = 0; g < 4; g++) begin
         #1;
         check("lim_grant", 64'(rd_rdy), 64'b01);
         push_ar(0, 32'h8000, 8'd0, 3'd2);
         tick();
      end
      #1;
      check("lim_block", 64'(rd_rdy), 64'd0);
      rvalid = 1; rid = 4'd0; rlast = 1; rdata = '0;
      #1;
      check("lim_block_rlast", 64'(rd_rdy), 64'd0);
      tick();
      rvalid = 0; rlast = 0;
      #1;
      check("lim_release", 64'(rd_rdy), 64'b01);
      push_ar(0, 32'h8000, 8'd0, 3'd2);
      tick();
      rd_req = 2'b00; rvalid = 1; rlast = 1; rid = 4'd0;
      tick();
      rd_req = 2'b01;
      #1;
      check("simul_rdy", 64'(rd_rdy), 64'b01);
      push_ar(0, 32'h8000, 8'd0, 3'd2);
      tick();
      rvalid = 0; rlast = 0; rd_req = 2'b00;
      #1;
      check("simul_rd_out", 64'(dut.r_rd_out[0]), 64'd3);
      rd_req = 2'b01;
      #1;
      check("simul_fill", 64'(rd_rdy), 64'b01);
      push_ar(0, 32'h8000, 8'd0, 3'd2);
      tick();
      #1;
      check("simul_full", 64'(rd_rdy), 64'd0);
      rd_req = 2'b00;
      tick(); tick();
      check("lim_drained", 64'(ar_q.size()), 64'd0);

      // Write burst with toggling wready
      do_reset();
      awready = 0; wready = 1;
      wr_req = 1; wr_addr = 32'h9000; wr_len = 8'd3; wr_size = 3'd2;
      #1;
      check("wb_addr_ok", 64'(wr_addr_ok), 64'd1);
      tick();
      wr_req = 0;
      for (int c = 0; c < 2; c++) begin
         #1;
         check("wb_aw_hold", 64'({awvalid, awaddr, awlen}), 64'({1'b1, 32'h9000, 8'd3}));
         check("wb_wready_gate", 64'(wr_wready), 64'd0);
         tick();
      end
      awready = 1;
      tick();
      w0 = w_seen; k = 0; cyc = 0;
      while (k < 4 && cyc < 20) begin
         wr_now = (cyc % 2 == 0);
         wready = wr_now; wr_wvalid = 1;
         wr_wdata = 32'hD0 + 32'(k); wr_wstrb = 4'(k + 1); wr_wlast = (k == 3);
         if (wr_now) w_q.push_back({4'hF, 32'hD0 + 32'(k), 4'(k + 1), (k == 3)});
         #1;
         check("wb_wready", 64'(wr_wready), 64'(wr_now));
         tick();
         if (wr_now) k++;
         cyc++;
      end
      wr_wvalid = 0; wr_wlast = 0; wready = 0;
      check("wb_done", 64'(k), 64'd4);
      check("wb_beats", 64'(w_seen - w0), 64'd4);
      wready = 1; wr_wvalid = 1;
      #1;
      check("wb_idle_wvalid", 64'(wvalid), 64'd0);
      wr_wvalid = 0; wready = 0;
      bvalid = 1; bid = 4'hF;
      #1;
      check("wb_data_ok", 64'(wr_data_ok), 64'd1);
      tick();
      bvalid = 0;
      #1;
      check("wb_data_ok_off", 64'(wr_data_ok), 64'd0);
      check("wb_wr_out", 64'(dut.r_wr_out), 64'd0);

      // AR stall: payload held while arready is low
      do_reset();
      arready = 0;
      rd_req = 2'b01; rd_addr[31:0] = 32'h3000; rd_len[7:0] = 8'd7; rd_size[2:0] = 3'd2;
      #1;
      check("stall_first", 64'(rd_rdy), 64'b01);
      push_ar(0, 32'h3000, 8'd7, 3'd2);
      tick();
      rd_addr[31:0] = 32'h3100;
      for (int c = 0; c < 5; c++) begin
         #1;
         check("stall_no_rdy", 64'(rd_rdy), 64'd0);
         check("stall_hold", 64'({arvalid, arid, araddr}), 64'({1'b1, 4'd0, 32'h3000}));
         tick();
      end
      rd_req = 2'b00; arready = 1;
      tick(); tick();
      check("stall_drained", 64'(ar_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/axi_bridge_mp.md
Name: axi_bridge_mp

Overview:
- Parametrised next-generation SRAM/cache-to-AXI3 bridge.
- Merges NUM_PORTS read-request ports (i-cache, d-cache, uncached) onto one AR/R channel pair, and one write port onto AW/W/B.
- Arbitrates AR and tracks outstanding reads per port.
- Blocks reads on flagged ports while a write is in flight (RAW ordering).
- Sits between the CPU cache layer and the AXI crossbar/RAM model.

Parameters:
- NUM_PORTS, 2, number of read ports (2..15); port p uses arid = p.
- MAX_RD_OUT, 4, max outstanding read bursts per port (1..15).
- MAX_WR_OUT, 4, max outstanding write bursts (1..15).
- WR_ID, 15, constant awid/wid; must be >= NUM_PORTS.
- RAW_MASK, 2'b10, bit p=1: port p is held off while any write is pending.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- rd_req  in  NUM_PORTS  per-port read request
- rd_addr  in  32*NUM_PORTS  read address, port p at [32p+31:32p]
- rd_len  in  8*NUM_PORTS  burst length minus 1
- rd_size  in  3*NUM_PORTS  beat size (AXI encoding)
- rd_rdy  out  NUM_PORTS  request accepted (one-hot, same cycle as rd_req)
- ret_valid  out  NUM_PORTS  read beat valid for port p
- ret_last  out  NUM_PORTS  last beat of burst for port p
- ret_data  out  32  read beat data (shared)
- wr_req  in  1  write request
- wr_addr  in  32  write address
- wr_len  in  8  write burst length minus 1
- wr_size  in  3  write beat size
- wr_addr_ok  out  1  write request accepted
- wr_wdata  in  32  write beat data
- wr_wstrb  in  4  write beat strobes
- wr_wlast  in  1  last write beat
- wr_wvalid  in  1  write beat valid
- wr_wready  out  1  write beat consumed
- wr_data_ok  out  1  write response received
- arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  out  4/32/8/3/2/2/4/3/1  AXI AR
- arready  in  1  AXI AR
- rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1  AXI R
- rready  out  1  AXI R
- awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid  out  AXI AW, same widths as AR
- awready  in  1  AXI AW
- wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1  AXI W
- wready  in  1  AXI W
- bid/bresp/bvalid  in  4/2/1  AXI B
- bready  out  1  AXI B

Behaviour:
- Reset (synchronous, active-high): arvalid=0, awvalid=0, wvalid=0, all counters=0, RR pointer=0, write FSM=W_IDLE.
- Constants:
  - arburst=awburst=2'b01; lock/cache/prot=0.
  - rready=1, bready=1.
  - awid=wid=WR_ID.
- Read eligibility: port p is eligible when all of the following hold:
  - rd_req[p]=1;
  - rd_out[p] < MAX_RD_OUT;
  - if RAW_MASK[p]=1: wr_out==0, write FSM==W_IDLE and wr_req==0.
- AR acceptance:
  - Happens when (arvalid==0 or arready==1) and at least one port is eligible.
  - Grant goes to one port; rd_rdy[g]=1 combinationally in that cycle.
  - {g, addr, len, size} are registered into the AR register; arvalid=1 next cycle.
  - Latency from rd_req to arvalid: 1 cycle.
  - Back-to-back AR is supported when arready=1.
  - arvalid/payload hold stable until arready.
- rd_out[p]:
  - +1 on grant.
  - -1 on rvalid&rlast&rid==p.
  - Both events in the same cycle: unchanged.
- R demux:
  - ret_valid[p] = rvalid & (rid==p); ret_last[p] = rvalid & rlast & (rid==p); ret_data = rdata.
  - rid >= NUM_PORTS: beat dropped, no counter change.
- Write FSM: W_IDLE -> W_ADDR -> W_DATA -> W_IDLE.
  - W_IDLE: wr_addr_ok = wr_req & (wr_out < MAX_WR_OUT). On accept, latch the AW payload, go to W_ADDR.
  - W_ADDR: awvalid=1; on awready go to W_DATA.
  - W_DATA: wvalid=wr_wvalid, wdata/wstrb/wlast pass through, wr_wready=wready. On wvalid&wready&wlast go to W_IDLE.
  - wr_wready=0 in every other state.
- wr_out:
  - +1 on wr_addr_ok.
  - -1 on bvalid.
  - Both in the same cycle: unchanged.
- wr_data_ok = bvalid.
- A write accepted in the same cycle as a RAW_MASK read request always wins; the read waits.
- Reset mid-burst: all state is dropped; the AXI side must also be reset.

Optional Feature:
- Macro: AXI_BRIDGE_RR_ARB_EN.
- Defined: round-robin grant. Search starts at port ptr; after each grant ptr = (g+1) mod NUM_PORTS.
- Undefined: fixed priority, highest port index wins; no pointer register.

Test Plan:
- Single read: rd_req[0] addr 0x1000 len 3, arready=1 -> rd_rdy[0] in the same cycle; arvalid next cycle with arid=0, arlen=3; 4 R beats with rid=0 -> ret_valid[0] ×4, ret_last[0] on beat 4; rd_out[0] returns to 0.
- Contention: rd_req=2'b11 held for 4 grants.
  - With RR_ARB_EN: grants alternate 0,1,0,1.
  - Without: port 1 granted ×4 while port 0 is starved.
- RAW block: write len 0 accepted, bvalid delayed 10 cycles, rd_req[1] held -> no rd_rdy[1] until the cycle after bvalid; rd_req[0] meanwhile granted.
- Outstanding limit: MAX_RD_OUT=4, no R returned -> port 0 gets exactly 4 grants, 5th blocked; one rlast with rid=0 -> 5th granted next cycle.
- Write burst: wr_len=3, wready toggling 1/0 -> exactly 4 W beats, wlast on beat 4; awid=wid=15; wr_data_ok on bvalid.
- Simultaneous: grant and rlast for the same port in one cycle -> rd_out unchanged; AR stall (arready=0 for 5 cycles) -> araddr/arid stable.
